// File: rtl/seg7_bin_display.sv
// Iterative double-dabble binary-to-decimal converter driving DIGITS active-low
// 7-segment bytes, with leading-zero blanking, minus sign and overflow display.
module seg7_bin_display #(
  parameter int WIDTH    = 10,
  parameter int DIGITS   = 4,
  parameter bit SIGNED   = 1'b0,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  MAX10_CLK1_50,
  input  logic                  RESET,
  input  logic [WIDTH-1:0]      BIN,
  input  logic                  LOAD,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  OVF,
  output logic [8*DIGITS-1:0]   HEX
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_e;

  state_e              state_q;
  logic [WIDTH-1:0]    mag_q;
  logic                sign_q;
  logic [BW-1:0]       bcd_q;
  logic                flow_q;
  logic [CW-1:0]       cnt_q;
  logic                busy_q, done_q, ovf_q;
  logic [8*DIGITS-1:0] hex_q;

  logic                  load_sign;
  logic [WIDTH-1:0]      load_mag;
  logic [BW-1:0]         bcd_adj;
  logic [BW+WIDTH:0]     shifted;
  logic [8*DIGITS-1:0]   hex_d;
  logic                  ovf_d;
  int                    msd;
  int                    minus_pos;

  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  endfunction

  // The most negative input maps to 2^(WIDTH-1), which still fits WIDTH unsigned bits.
  assign load_sign = SIGNED && BIN[WIDTH-1];
  assign load_mag  = load_sign ? (~BIN + WIDTH'(1)) : BIN;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    // Top bit is the carry out of the most significant nibble.
    shifted = {1'b0, bcd_adj, mag_q} << 1;
  end

  always_comb begin
    msd = 0;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] != 4'd0) msd = k;
    end
    ovf_d     = flow_q || (sign_q && (bcd_q[BW-1 -: 4] != 4'd0));
    minus_pos = BLANK_LZ ? msd + 1 : DIGITS - 1;
    hex_d     = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (ovf_d)                                  hex_d[8*k +: 8] = 8'hBF;
      else if (sign_q && (|bcd_q) && k == minus_pos) hex_d[8*k +: 8] = 8'hBF;
      else if (BLANK_LZ && k > msd)               hex_d[8*k +: 8] = 8'hFF;
      else                                        hex_d[8*k +: 8] = seg(bcd_q[4*k +: 4]);
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (RESET) begin
      state_q <= IDLE;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      flow_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      hex_q   <= '1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (LOAD) begin
            mag_q   <= load_mag;
            sign_q  <= load_sign;
            bcd_q   <= '0;
            flow_q  <= 1'b0;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_q, mag_q} <= shifted[BW+WIDTH-1:0];
          flow_q         <= flow_q | shifted[BW+WIDTH];
          cnt_q          <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= ENCODE;
        end
        ENCODE: begin
          hex_q   <= hex_d;
          ovf_q   <= ovf_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign OVF  = ovf_q;
  assign HEX  = hex_q;

endmodule

// File: doc/seg7_bin_display.md
# seg7_bin_display

Sequential binary-to-decimal converter and multi-digit 7-segment encoder: the parametrised successor of the combinational switch-to-HEX converters used in the DE10-Lite top levels. It accepts a WIDTH-bit unsigned or two's-complement value on a LOAD strobe and runs an iterative double-dabble conversion, one bit per clock. It drives DIGITS active-low HEX digit bytes with optional leading-zero blanking, a minus sign, and an overflow indication. It sits between any value source (switches, counters, ADC) and the board HEX outputs.

## Interface
- WIDTH, 10, input value width in bits, ≥ 2.
- DIGITS, 4, number of HEX digits driven, 1–6.
- SIGNED, 0, 1 = BIN is two's-complement.
- BLANK_LZ, 1, 1 = blank leading zeros.
- MAX10_CLK1_50  input  1  clock; all logic on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- BIN  input  WIDTH  value to convert; sampled only on an accepted LOAD.
- LOAD  input  1  start strobe; accepted only when BUSY = 0.
- BUSY  output  1  conversion in progress.
- DONE  output  1  one-cycle pulse when HEX/OVF are updated.
- OVF  output  1  last converted value did not fit the display.
- HEX  output  8*DIGITS  digit k at [8k+7:8k], digit 0 rightmost. Each byte is active-low: bit0 = a … bit6 = g, bit7 = DP (always 1).

## Operation
- **Single clock.** One clock (MAX10_CLK1_50); synchronous active-high RESET.
- **FSM states:** IDLE → SHIFT → ENCODE → IDLE.
- **IDLE.**
  - LOAD = 1 captures magnitude M and sign S, clears the BCD register and the overflow flag, loads the shift counter with WIDTH, and moves to SHIFT.
  - Unsigned: M = BIN, S = 0.
  - Signed: S = BIN[WIDTH-1], M = |BIN| as WIDTH-bit unsigned (−2^(WIDTH−1) → 2^(WIDTH−1)).
- **SHIFT.**
  - Each cycle: add 3 to every BCD nibble ≥ 5, then shift {BCD, M} left by one.
  - A 1 shifted out of the top nibble sets the sticky overflow flag.
  - Transition to ENCODE after WIDTH shifts.
- **ENCODE (one cycle).** Compute and register HEX and OVF, pulse DONE, return to IDLE.
  - Overflow condition: the overflow flag is set, or S = 1 and the magnitude occupies all DIGITS digits (no room for the sign).
  - On overflow: every digit = minus (0xBF), OVF = 1.
  - Otherwise, digit codes: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, blank FF, minus BF.
  - Leading-zero blanking (BLANK_LZ = 1): zero digits above the most significant nonzero digit are blanked. Digit 0 is never blanked, so a value of 0 shows "0".
  - Minus sign: when S = 1 and the magnitude is nonzero, minus goes in the digit just above the most significant nonzero digit if BLANK_LZ = 1, else in digit DIGITS−1. Negative zero cannot occur.
- **LOAD while BUSY = 1** is ignored; no queueing.
- **HEX/OVF hold** their last value between conversions.

## Timing
- **Reset values:** HEX all 0xFF (blank), OVF 0, DONE 0, BUSY 0, FSM IDLE.
- **Reset mid-conversion:** aborts, returns to IDLE, blanks HEX, and produces no DONE pulse.
- **Edge numbering:** E0 is the edge sampling LOAD = 1 in IDLE. BUSY = 1 from after E0 through E(WIDTH+1).
- **SHIFT window:** shifts occur at E1 … E(WIDTH).
- **Output update:** HEX/OVF update at E(WIDTH+1). DONE = 1 for exactly the cycle after E(WIDTH+1); BUSY = 0 in that same cycle.
- **Latency:** WIDTH+1 cycles from accept to valid output.
- **Back-to-back:** LOAD asserted during the DONE cycle is accepted, giving a restart period of WIDTH+2 cycles.
- **RESET precedence:** RESET has priority over LOAD in the same cycle.

## Test plan
- **Unsigned maximum:** WIDTH=10, DIGITS=4, SIGNED=0, BIN=1023, LOAD one cycle → HEX3..0 = F9 C0 A4 B0, OVF=0, DONE exactly 11 cycles after the accept edge, BUSY high for 11 cycles.
- **Blanking:**
  - BIN=7 → FF FF FF F8.
  - BIN=0 → FF FF FF C0.
  - Repeat with BLANK_LZ=0: BIN=7 → C0 C0 C0 F8.
- **Signed:** WIDTH=8, DIGITS=4, SIGNED=1.
  - BIN=0x80 → BF F9 A4 80 ("-128").
  - BIN=0xFB → FF FF BF 92 ("-5").
  - BIN=0x7F → FF F9 A4 F8.
- **Overflow:**
  - WIDTH=10, DIGITS=2, SIGNED=0, BIN=100 → BF BF, OVF=1.
  - Then BIN=99 → 90 90, OVF=0.
  - SIGNED=1, WIDTH=8, DIGITS=3, BIN=0x80 → BF BF BF, OVF=1.
- **Handshake:**
  - LOAD pulsed at cycles 3 and 6 after an accept → only the first is converted, one DONE.
  - LOAD held high continuously → conversions every WIDTH+2 cycles.
- **Reset mid-operation:** RESET for one cycle during shift 5 → next cycle BUSY=0, HEX all FF, no DONE. A subsequent LOAD converts correctly.
